// File: rtl/tx_fifo.sv
// tx_fifo: synchronous transmit FIFO between the RMAP reply generator and the
// SpaceWire transmitter. Carries 9-bit N-chars (bit 8 = control flag) in order,
// with a registered (non-fall-through) read port and registered status flags.
module tx_fifo #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEnable,
  input  logic [WIDTH-1:0]      dataIn,
  output logic                  full,
  input  logic                  readEnable,
  output logic [WIDTH-1:0]      dataOut,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   usedWords
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

  // Storage; no reset so it maps onto block RAM.
  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic [WIDTH-1:0]      r_data_out;

  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_count_next;

  // Legality is judged on the flags as they stand before the edge, so a
  // push at full or a pop at empty is silently dropped.
  assign w_push = writeEnable & ~r_full;
  assign w_pop  = readEnable  & ~r_empty;

  // Next occupancy: simultaneous legal push and pop leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Memory write port; a push at full never reaches here, so the slot being
  // read out is never overwritten in the same cycle.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

  // Pointers, occupancy and flags; flags are derived from the next count so
  // they change on the same edge as the operation that causes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  // Registered read port: loads only on a legal pop, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (w_pop) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign full      = r_full;
  assign empty     = r_empty;
  assign usedWords = r_count;
  assign dataOut   = r_data_out;

endmodule

// File: tb/tb_tx_fifo.sv
// tb_tx_fifo: scoreboard bench for tx_fifo. A reference queue tracks the FIFO
// contents; every legal pop pushes the expected word to a scoreboard queue,
// which is popped and compared once dataOut has been updated.
module tb_tx_fifo;

  localparam int WIDTH = 9;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 16;

  logic                 clk;
  logic                 rst;
  logic                 writeEnable;
  logic [WIDTH-1:0]     dataIn;
  logic                 full;
  logic                 readEnable;
  logic [WIDTH-1:0]     dataOut;
  logic                 empty;
  logic [DEPTH_LOG2:0]  usedWords;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_out;

  tx_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (writeEnable),
    .dataIn      (dataIn),
    .full        (full),
    .readEnable  (readEnable),
    .dataOut     (dataOut),
    .empty       (empty),
    .usedWords   (usedWords)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check_val({tag, ".usedWords"}, 32'(usedWords), 32'(model_q.size()));
    check_val({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    check_val({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  // One clock: drive at the falling edge, DUT samples on the rising edge,
  // outputs are checked at the next falling edge.
  task automatic step(input logic we, input logic [WIDTH-1:0] d, input logic re, input string tag);
    bit do_push;
    bit do_pop;
    do_push = we && (model_q.size() < DEPTH);
    do_pop  = re && (model_q.size() > 0);
    writeEnable = we;
    dataIn      = d;
    readEnable  = re;
    if (do_pop) exp_q.push_back(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    @(negedge clk);
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    if (do_pop) begin
      last_out = exp_q.pop_front();
      check_val({tag, ".dataOut"}, 32'(dataOut), 32'(last_out));
    end else begin
      check_val({tag, ".hold"}, 32'(dataOut), 32'(last_out));
    end
    check_status(tag);
    $display("%0t %s we=%0b din=0x%03h re=%0b -> dataOut=0x%03h used=%0d full=%0b empty=%0b",
             $time, tag, we, d, re, dataOut, usedWords, full, empty);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    writeEnable = 1'b1;
    dataIn = 9'h155;
    readEnable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    writeEnable = 1'b0;
    readEnable = 1'b0;
    model_q.delete();
    exp_q.delete();
    last_out = '0;
    check_val({tag, ".dataOut"}, 32'(dataOut), 32'h0);
    check_status(tag);
    $display("%0t %s reset -> dataOut=0x%03h used=%0d full=%0b empty=%0b",
             $time, tag, dataOut, usedWords, full, empty);
  endtask

  initial begin
    rst = 1'b1;
    writeEnable = 1'b0;
    readEnable = 1'b0;
    dataIn = '0;
    last_out = '0;

    // Reset held two cycles with writeEnable high.
    do_reset("reset");

    // Fill 0x000..0x00F, then one overflow push of 0x1AA.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 9'(i), 1'b0, "fill");
    check_val("fill.full_flag", 32'(full), 32'h1);
    step(1'b1, 9'h1AA, 1'b0, "overflow");
    check_val("overflow.used", 32'(usedWords), 32'd16);

    // Drain; scoreboard expects 0x000..0x00F and never 0x1AA.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain");
    check_val("drain.empty_flag", 32'(empty), 32'h1);

    // Underflow: pop from empty holds dataOut.
    step(1'b0, '0, 1'b1, "underflow");
    step(1'b0, '0, 1'b1, "underflow");

    // Five words stored, then 20 cycles of simultaneous push+pop across wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 9'(9'h040 + i), 1'b0, "prefill5");
    for (int i = 0; i < 20; i++) step(1'b1, 9'(9'h080 + i), 1'b1, "pushpop5");
    check_val("pushpop5.used", 32'(usedWords), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, "drain5");

    // Push+pop at full: pop only.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 9'($urandom_range(0, 511)), 1'b0, "fill_rnd");
    step(1'b1, 9'h1EE, 1'b1, "full_pp");
    check_val("full_pp.used", 32'(usedWords), 32'd15);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, "drain_rnd");

    // Push+pop at empty: push only.
    step(1'b1, 9'h0C3, 1'b1, "empty_pp");
    check_val("empty_pp.used", 32'(usedWords), 32'd1);
    step(1'b0, '0, 1'b1, "empty_pp_pop");

    // Control flag passes through untouched.
    step(1'b1, 9'h100, 1'b0, "ctrl_push");
    step(1'b1, 9'h0FF, 1'b0, "ctrl_push");
    step(1'b0, '0, 1'b1, "ctrl_pop");
    check_val("ctrl.eop", 32'(dataOut), 32'h100);
    step(1'b0, '0, 1'b1, "ctrl_pop");
    check_val("ctrl.data", 32'(dataOut), 32'h0FF);

    // Reset mid-stream discards stored words.
    for (int i = 0; i < 3; i++) step(1'b1, 9'(9'h0A0 + i), 1'b0, "pre_rst");
    step(1'b0, '0, 1'b1, "pre_rst_pop");
    do_reset("mid_reset");
    step(1'b0, '0, 1'b1, "post_rst_pop");
    step(1'b1, 9'h055, 1'b0, "post_rst_push");
    step(1'b0, '0, 1'b1, "post_rst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
